// File: rtl/demux4_dispatch.sv
// 1-to-4 registered dispatcher: one input word is routed by i_sel into one of four
// single-entry output registers, each drained independently with a valid/ready handshake.
module demux4_dispatch #(
    parameter int NB_DATA = 32,
    parameter int NB_SEL  = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_valid,
    input  logic [NB_SEL-1:0]            i_sel,
    input  logic [NB_DATA-1:0]           i_data,
    output logic                         o_ready,
    output logic [(2**NB_SEL)-1:0]       o_valid,
    output logic [(2**NB_SEL)*NB_DATA-1:0] o_data,
    input  logic [(2**NB_SEL)-1:0]       i_ready,
    output logic [7:0]                   o_count
);

    localparam int NCH = 2**NB_SEL;

    logic [NCH-1:0]     valid_q, valid_d;
    logic [NB_DATA-1:0] data_q [NCH];
    logic [NB_DATA-1:0] data_d [NCH];
    logic [7:0]         count_q, count_d;
    logic               accept;

    // The selected channel can take a word when it is empty or is being drained this cycle.
    assign o_ready = !i_reset && (!valid_q[i_sel] || i_ready[i_sel]);
    assign accept  = i_valid && o_ready;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can leave a latch.
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        for (int k = 0; k < NCH; k++) begin
            if (valid_q[k] && i_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        if (accept) begin
            valid_d[i_sel] = 1'b1;
            data_d[i_sel]  = i_data;
            count_d        = count_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= '0;
            count_q <= '0;
            // NOTE: the channel data registers are cleared too, because consumers see zeros after reset.
            for (int k = 0; k < NCH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign o_data[g*NB_DATA +: NB_DATA] = data_q[g];
    end

    assign o_valid = valid_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_demux4_dispatch.sv
// Scoreboard bench for demux4_dispatch: per-channel expected-word queues are filled on
// accept and popped by a negedge monitor whenever a channel hands a word to its consumer.
module tb_demux4_dispatch;

    localparam int NB_DATA = 32;
    localparam int NB_SEL  = 2;

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic                 i_valid;
    logic [NB_SEL-1:0]    i_sel;
    logic [NB_DATA-1:0]   i_data;
    logic                 o_ready;
    logic [3:0]           o_valid;
    logic [4*NB_DATA-1:0] o_data;
    logic [3:0]           i_ready;
    logic [7:0]           o_count;

    demux4_dispatch #(.NB_DATA(NB_DATA), .NB_SEL(NB_SEL)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_sel   (i_sel),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words waiting in each channel, last word loaded per channel, accept count.
    logic [NB_DATA-1:0] exp_q [4][$];
    logic [NB_DATA-1:0] last_data [4];
    logic [7:0]         cnt_m = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle; compare, then retire words the consumers take at the next edge.
    always @(negedge i_clk) begin
        logic                exp_ready;
        logic                exp_v;
        logic [NB_DATA-1:0]  exp_d;
        exp_ready = !i_reset && (exp_q[i_sel].size() == 0 || i_ready[i_sel]);
        check("o_ready", 64'(o_ready), 64'(exp_ready));
        check("o_count", 64'(o_count), 64'(cnt_m));
        for (int k = 0; k < 4; k++) begin
            exp_v = (exp_q[k].size() != 0);
            exp_d = exp_v ? exp_q[k][0] : last_data[k];
            check($sformatf("o_valid[%0d]", k), 64'(o_valid[k]), 64'(exp_v));
            check($sformatf("o_data[%0d]", k), 64'(o_data[k*NB_DATA +: NB_DATA]), 64'(exp_d));
        end
        if (i_reset) begin
            for (int k = 0; k < 4; k++) begin
                exp_q[k].delete();
                last_data[k] = '0;
            end
            cnt_m = 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (o_valid[k] && i_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("unexpected delivery ch%0d", k), 64'(1), 64'(0));
                    end else begin
                        exp_d = exp_q[k].pop_front();
                        check($sformatf("delivered ch%0d", k), 64'(o_data[k*NB_DATA +: NB_DATA]), 64'(exp_d));
                    end
                end
            end
        end
    end

    // One clock of stimulus; after the monitor has retired drains, a channel accepts only if now empty.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic [3:0] r, input logic rst);
        @(posedge i_clk);
        #1;
        i_valid = v;
        i_sel   = s;
        i_data  = d;
        i_ready = r;
        i_reset = rst;
        @(negedge i_clk);
        #2;
        if (i_valid && !i_reset && exp_q[i_sel].size() == 0) begin
            exp_q[i_sel].push_back(i_data);
            last_data[i_sel] = i_data;
            cnt_m = cnt_m + 8'd1;
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) last_data[k] = '0;
        i_reset = 1'b1;
        i_valid = 1'b1;
        i_sel   = 2'd0;
        i_data  = 32'h0;
        i_ready = 4'b0000;

        // Reset held two cycles with a word offered.
        cycle(1'b1, 2'd1, 32'h1234_5678, 4'b0000, 1'b1);
        cycle(1'b1, 2'd1, 32'h1234_5678, 4'b0000, 1'b1);

        // Basic route, blocked same-channel word, accepted other channel.
        cycle(1'b1, 2'd2, 32'hDEAD_BEEF, 4'b0000, 1'b0);
        cycle(1'b1, 2'd2, 32'h1111_1111, 4'b0000, 1'b0);
        cycle(1'b1, 2'd1, 32'hCAFE_0001, 4'b0000, 1'b0);

        // Hold stability, then a single-cycle drain of channel 2.
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd2, $urandom, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b0100, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);

        // Back-to-back reloads of channel 3 with its consumer always ready.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 2'd3, 32'(i), 4'b1111, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);

        // Fill all four channels, reset once, confirm nothing surfaces afterwards.
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 32'hA000_0000 + 32'(i), 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);

        // Counter wrap: 257 accepts from a fresh reset.
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, 1'b1);
        for (int i = 0; i < 257; i++) cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, 4'b1111, 1'b0);

        // Randomized traffic with independent stalls and rare resets.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 199) == 0);
        end

        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        @(negedge i_clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux4_dispatch.md
Name: demux4_dispatch

Overview:
- 1-to-4 registered dispatcher: the reverse of the pipeline's 4:1 selection muxes.
- Takes one input word with a 2-bit destination select and routes it to one of four output channels.
- Each output channel holds the word in a one-entry register with valid/ready handshake.
- Used where a single producer (e.g. debug/loader data path) feeds one of four pipeline-side consumers that may stall independently.

Parameters:
- NB_DATA, 32, width of each data word.
- NB_SEL, 2, width of destination select; channel count is fixed at 4 = 2**NB_SEL.

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  input word present.
- i_sel  input  NB_SEL  destination channel 0..3 for the input word.
- i_data  input  NB_DATA  input word.
- o_ready  output  1  dispatcher can accept the input word this cycle.
- o_valid  output  4  per-channel word valid; bit k = channel k.
- o_data  output  4*NB_DATA  packed channel registers; channel k at bits [k*NB_DATA +: NB_DATA].
- i_ready  input  4  per-channel consumer ready; bit k = channel k.
- o_count  output  8  total words accepted since reset, wrapping modulo 256.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - o_valid=4'b0000, all o_data channels=0, o_count=0.
  - o_ready=0 combinationally while i_reset=1.
  - Pending words are discarded, not delivered.
- Per-channel state per k: empty (o_valid[k]=0) / full (o_valid[k]=1). Register plus valid bit; no other FSM.
- Drain: drain[k] = o_valid[k] & i_ready[k].
- Ready (combinational): o_ready = !i_reset & (!o_valid[i_sel] | i_ready[i_sel]). Depends only on the selected channel.
  - Contains a combinational path i_ready/i_sel -> o_ready.
  - Producer must not make i_valid depend on o_ready.
- Accept: accept = i_valid & o_ready. Loads channel k = i_sel.
- Next state per channel k at rising edge:
  - accept & i_sel==k: o_data[k] <= i_data, o_valid[k] <= 1.
  - else if drain[k]: o_valid[k] <= 0; o_data[k] holds its last value.
  - else: no change.
- Latency: a word accepted at edge N is visible on o_valid/o_data from edge N onward, i.e. one cycle after it was presented.
- Throughput: 1 word/cycle aggregate; same channel sustains 1 word/cycle when its i_ready is held high.
- Stability: while o_valid[k]=1 and i_ready[k]=0, o_data[k] must not change.
- Blocking:
  - Input stalls (o_ready=0) only when the selected channel is full and not draining.
  - Other channels keep draining meanwhile. Head-of-line blocking on the input is accepted.
- Simultaneous drain and reload of the same channel: valid stays 1, data replaced by i_data. No bubble, no loss, no duplication.
- Simultaneous drains on several channels in one cycle are independent.
- i_valid=0: i_sel/i_data ignored, no state change except drains.
- o_count increments by 1 on each accept; 255 -> 0 wrap; unaffected by drains.
- Ordering: words to the same channel are delivered in acceptance order (trivially, depth 1). No ordering guarantee across channels.

Test Plan:
- Reset: hold i_reset=1 for 2 cycles with i_valid=1 -> o_ready=0, o_valid=0000, o_data=0, o_count=0; release -> o_ready=1.
- Basic route: i_ready=0000, present sel=2 data=0xDEADBEEF -> next cycle o_valid=0100, channel 2 =0xDEADBEEF, o_count=1. Then present sel=2 again -> o_ready=0; present sel=1 -> accepted, o_valid=0110.
- Hold stability: channel 2 full, i_ready[2]=0 for 5 cycles -> data constant 0xDEADBEEF. Raise i_ready[2] one cycle -> o_valid[2]=0 next cycle.
- Back-to-back same channel: i_ready=1111, sel=3, data 1,2,3,4 on consecutive cycles -> o_ready stays 1; channel 3 shows 1,2,3,4 on successive cycles, valid never drops; o_count +4.
- Reset mid-operation: all four channels full, assert i_reset 1 cycle -> o_valid=0000, o_count=0, no word appears later.
- Counter wrap: 256 accepts -> o_count returns to 0; 257th -> 1.
